// File: rtl/mem_stream_reader.sv
// Burst read engine: fetches up to 64 samples from a 1-cycle-latency memory into a valid/ready stream.
// Optional running sum of accepted beats is enabled with `define MEM_READER_SUM_EN.
module mem_stream_reader #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
`ifdef MEM_READER_SUM_EN
  ,
  output logic [DATA_W+ADDR_W-1:0] sum
`endif
);

  localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W+1)'(1 << ADDR_W);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   issue_q, issue_d;
  logic [ADDR_W:0]   beat_q, beat_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              inflight_q, inflight_d;
  logic [DATA_W-1:0] buf_q [2];
  logic [DATA_W-1:0] buf_d [2];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              fire_s;
  logic              rd_en_s;
  logic [2:0]        occ_s;
  logic [ADDR_W:0]   len_in_s;
`ifdef MEM_READER_SUM_EN
  logic [DATA_W+ADDR_W-1:0] sum_q, sum_d;
  assign sum = sum_q;
`endif

  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = buf_q[rd_ptr_q];
  assign out_last  = out_valid && (beat_q == (len_q - (ADDR_W+1)'(1)));
  assign fire_s    = out_valid && out_ready;
  // Slots committed after this cycle's pop; a new read may claim one only if one stays free.
  assign occ_s     = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, fire_s};
  assign rd_en_s   = (state_q == S_READ) && (issue_q != len_q) && (occ_s < 3'd2);
  assign mem_rd_en = rd_en_s;
  assign mem_addr  = base_q + issue_q[ADDR_W-1:0];
  assign busy      = busy_q;
  assign done      = done_q;
  assign len_in_s  = (length > MAX_LEN) ? MAX_LEN : length;

  // Next-state computation for the control FSM, counters and the two-entry output buffer.
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    len_d      = len_q;
    issue_d    = issue_q;
    beat_d     = beat_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    inflight_d = rd_en_s;
    buf_d[0]   = buf_q[0];
    buf_d[1]   = buf_q[1];
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q + {1'b0, inflight_q} - {1'b0, fire_s};
`ifdef MEM_READER_SUM_EN
    sum_d      = sum_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d  = base_addr;
          len_d   = len_in_s;
          issue_d = '0;
          beat_d  = '0;
`ifdef MEM_READER_SUM_EN
          sum_d   = '0;
`endif
          if (len_in_s == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_READ;
            busy_d  = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        if (rd_en_s) begin
          issue_d = issue_q + (ADDR_W+1)'(1);
          state_d = (issue_q + (ADDR_W+1)'(1) == len_q) ? S_DRAIN : S_READ;
        end else begin
          state_d = S_READ;
        end
      end
      S_DRAIN: state_d = S_DRAIN;
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase

    if (inflight_q) begin
      buf_d[wr_ptr_q] = mem_data;
      wr_ptr_d        = ~wr_ptr_q;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (fire_s) begin
      rd_ptr_d = ~rd_ptr_q;
      beat_d   = beat_q + (ADDR_W+1)'(1);
`ifdef MEM_READER_SUM_EN
      sum_d    = sum_q + {{ADDR_W{1'b0}}, out_data};
`endif
      if (out_last) begin
        state_d = S_DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end else begin
        done_d = 1'b0;
      end
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // State register; an asynchronous reset discards any partial burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      len_q      <= '0;
      issue_q    <= '0;
      beat_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      inflight_q <= 1'b0;
      buf_q[0]   <= '0;
      buf_q[1]   <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      cnt_q      <= 2'd0;
`ifdef MEM_READER_SUM_EN
      sum_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      len_q      <= len_d;
      issue_q    <= issue_d;
      beat_q     <= beat_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      inflight_q <= inflight_d;
      buf_q[0]   <= buf_d[0];
      buf_q[1]   <= buf_d[1];
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
`ifdef MEM_READER_SUM_EN
      sum_q      <= sum_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_stream_reader.sv
// Directed self-checking bench for mem_stream_reader with a 64x8 memory model holding mem[i]=i.
// Sum checks are compiled in when MEM_READER_SUM_EN is defined.
module tb_mem_stream_reader;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 6;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [ADDR_W:0]   length = '0;
  logic              busy, done, mem_rd_en, out_valid, out_last;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data = '0;
  logic [DATA_W-1:0] out_data;
  logic              out_ready = 1'b1;
`ifdef MEM_READER_SUM_EN
  logic [DATA_W+ADDR_W-1:0] sum;
`endif

  mem_stream_reader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_data(mem_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
`ifdef MEM_READER_SUM_EN
    , .sum(sum)
`endif
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] mem [64];
  initial for (int i = 0; i < 64; i++) mem[i] = 8'(i);
  always @(posedge clk) if (mem_rd_en) mem_data <= mem[mem_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Monitor: logs reads, beats and done pulses; tracks occupancy and stall stability.
  int rd_cyc[$], rd_addr[$], beat_val[$], beat_cyc[$], beat_last[$], done_cyc[$];
  int rd_total = 0, beat_total = 0, valid_total = 0, occ_adj = 0;
  int stall_err = 0, occ_err = 0;
  bit prev_valid = 1'b0, prev_fire = 1'b0;
  int prev_data = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      occ_adj    = rd_total - beat_total;
      prev_valid = 1'b0;
      prev_fire  = 1'b0;
    end else begin
      if (rd_total - beat_total - occ_adj > 2) occ_err++;
      if (prev_valid && !prev_fire && (!out_valid || int'(out_data) != prev_data)) stall_err++;
      if (mem_rd_en) begin
        rd_total++;
        rd_cyc.push_back(cyc);
        rd_addr.push_back(int'(mem_addr));
      end
      if (out_valid) valid_total++;
      if (out_valid && out_ready) begin
        beat_total++;
        beat_val.push_back(int'(out_data));
        beat_cyc.push_back(cyc);
        beat_last.push_back(int'(out_last));
      end
      if (done) done_cyc.push_back(cyc);
      prev_valid = out_valid;
      prev_fire  = out_valid && out_ready;
      prev_data  = int'(out_data);
    end
  end

  int t0 = 0;
  int s_rd = 0, s_beat = 0, s_done = 0, s_valid = 0;

  task automatic start_burst(input int b, input int len);
    @(posedge clk); #1;
    s_rd = rd_cyc.size(); s_beat = beat_val.size(); s_done = done_cyc.size(); s_valid = valid_total;
    start = 1'b1; base_addr = 6'(b); length = 7'(len);
    @(posedge clk); #1;
    t0 = cyc;
    start = 1'b0; base_addr = 6'd42; length = 7'd9;
  endtask

  task automatic run_until_done(input int budget, input bit bp);
    int k = 0;
    while (done_cyc.size() == s_done && k < budget) begin
      @(posedge clk); #1;
      if (bp) out_ready = (k % 3 == 0);
      k++;
    end
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_burst(input string tag, input int b, input int len, input bit timed);
    int nb, na, bad_v, bad_a, last_idx, nl, exp_done;
    nb = beat_val.size() - s_beat;
    na = rd_addr.size() - s_rd;
    bad_v = 0; bad_a = 0; last_idx = -1; nl = 0;
    check_eq({tag, "_beats"}, nb, len);
    check_eq({tag, "_reads"}, na, len);
    check_eq({tag, "_done_cnt"}, done_cyc.size() - s_done, 1);
    for (int i = 0; i < nb; i++) begin
      if (beat_val[s_beat+i] != (b + i) % 64) bad_v++;
      if (beat_last[s_beat+i] != 0) begin nl++; last_idx = i; end
    end
    for (int i = 0; i < na; i++) if (rd_addr[s_rd+i] != (b + i) % 64) bad_a++;
    check_eq({tag, "_bad_data"}, bad_v, 0);
    check_eq({tag, "_bad_addr"}, bad_a, 0);
    check_eq({tag, "_last_cnt"}, nl, (len > 0) ? 1 : 0);
    check_eq({tag, "_last_idx"}, last_idx, len - 1);
    check_eq({tag, "_busy_after"}, int'(busy), 0);
    if (timed) begin
      exp_done = (len == 0) ? 1 : len + 3;
      check_eq({tag, "_done_rel"}, (done_cyc.size() > s_done) ? done_cyc[s_done] - t0 + 1 : -1, exp_done);
      check_eq({tag, "_valid_cycles"}, valid_total - s_valid, len);
      if (len > 0) begin
        check_eq({tag, "_first_rd_rel"}, (na > 0) ? rd_cyc[s_rd] - t0 + 1 : -1, 1);
        check_eq({tag, "_first_beat_rel"}, (nb > 0) ? beat_cyc[s_beat] - t0 + 1 : -1, 3);
        check_eq({tag, "_last_beat_rel"}, (nb > 0) ? beat_cyc[beat_cyc.size()-1] - t0 + 1 : -1, len + 2);
      end
    end
  endtask

  initial begin
    int k;
    #12;
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_done", int'(done), 0);
    check_eq("rst_rd_en", int'(mem_rd_en), 0);
    check_eq("rst_addr", int'(mem_addr), 0);
    check_eq("rst_valid", int'(out_valid), 0);
    check_eq("rst_data", int'(out_data), 0);
    check_eq("rst_last", int'(out_last), 0);
`ifdef MEM_READER_SUM_EN
    check_eq("rst_sum", int'(sum), 0);
`endif
    #1 rst_n = 1'b1;

    start_burst(0, 4);
    check_eq("basic_busy", int'(busy), 1);
    run_until_done(100, 1'b0);
    check_burst("basic", 0, 4, 1'b1);
`ifdef MEM_READER_SUM_EN
    check_eq("basic_sum", int'(sum), 6);
`endif

    start_burst(62, 4);
    run_until_done(100, 1'b0);
    check_burst("wrap", 62, 4, 1'b1);

    start_burst(0, 8);
    run_until_done(200, 1'b1);
    check_burst("bp", 0, 8, 1'b0);
    check_eq("bp_stall_stable", stall_err, 0);
    check_eq("bp_occupancy", occ_err, 0);

    start_burst(0, 0);
    run_until_done(20, 1'b0);
    check_burst("len0", 0, 0, 1'b1);

    start_burst(5, 64);
    run_until_done(300, 1'b0);
    check_burst("full", 5, 64, 1'b1);
`ifdef MEM_READER_SUM_EN
    check_eq("full_sum", int'(sum), 2016);
`endif

    start_burst(0, 100);
    run_until_done(300, 1'b0);
    check_burst("clamp", 0, 64, 1'b1);

    // Mid-burst reset while beat 3 is on the stream.
    start_burst(0, 8);
    k = 0;
    while (beat_val.size() - s_beat < 3 && k < 50) begin
      @(posedge clk);
      k++;
    end
    #2;
    check_eq("pre_rst_valid", int'(out_valid), 1);
    check_eq("pre_rst_data", int'(out_data), 3);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_busy", int'(busy), 0);
    check_eq("mid_rst_rd_en", int'(mem_rd_en), 0);
    check_eq("mid_rst_addr", int'(mem_addr), 0);
    check_eq("mid_rst_valid", int'(out_valid), 0);
    check_eq("mid_rst_data", int'(out_data), 0);
    check_eq("mid_rst_last", int'(out_last), 0);
`ifdef MEM_READER_SUM_EN
    check_eq("mid_rst_sum", int'(sum), 0);
`endif
    #20;
    @(negedge clk);
    rst_n = 1'b1;
    start_burst(0, 2);
    run_until_done(100, 1'b0);
    check_burst("rerun", 0, 2, 1'b1);

    // A start pulse while busy must not disturb the burst in progress.
    start_burst(0, 4);
    @(posedge clk); #1;
    start = 1'b1; base_addr = 6'd20; length = 7'd3;
    @(posedge clk); #1;
    start = 1'b0;
    run_until_done(100, 1'b0);
    check_burst("busy_start", 0, 4, 1'b1);

    check_eq("final_stall_stable", stall_err, 0);
    check_eq("final_occupancy", occ_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
